// File: rtl/inst_fetch_queue.sv
// Byte-serial instruction fetch with pre-decode and a circular queue that feeds the ROB.
// Optional macro FETCH_PREDICT_EN: statically redirect fetch to the JAL target when a JAL is pushed.
module inst_fetch_queue #(
   parameter int unsigned IQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        mem_grant,
   input  logic [7:0]  mem_din,
   output logic        mem_req,
   output logic [31:0] mem_a,
   input  logic        rob_full,
   input  logic        flush_in,
   input  logic [31:0] flush_pc,
   output logic        have_input,
   output logic [31:0] instr_input,
   output logic [31:0] instr_input_pc,
   output logic [16:0] opcode_if,
   output logic [4:0]  rd_if,
   output logic [4:0]  rs1_if,
   output logic [4:0]  rs2_if,
   output logic [31:0] imm_if
);
   localparam int unsigned PtrW = $clog2(IQ_DEPTH);
   localparam int unsigned CntW = $clog2(IQ_DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(IQ_DEPTH);
   localparam logic [6:0] OpJal = 7'b1101111;

   typedef enum logic [1:0] {StIdle, StIssue, StPush} state_e;

   function automatic logic [31:0] decode_imm(input logic [31:0] w);
      logic [31:0] imm;
      imm = '0;
      case (w[6:0])
         7'b0000011, 7'b1100111: imm = {{20{w[31]}}, w[31:20]};
         // funct3 001/101 are the shift-immediates: shamt is unsigned
         7'b0010011: imm = (w[13:12] == 2'b01) ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
         7'b0100011: imm = {{20{w[31]}}, w[31:25], w[11:7]};
         7'b1100011: imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
         7'b0110111, 7'b0010111: imm = {w[31:12], 12'b0};
         OpJal: imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   state_e          state_q, state_d;
   logic [1:0]      k_q, k_d, pend_idx_q, pend_idx_d;
   logic            pend_q, pend_d;
   logic [31:0]     pc_q, pc_d, word_q, word_d, word_cur, push_imm;
   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic            issue, push, pop, not_empty;
   logic [31:0]     head_word;

   logic [31:0] q_word [IQ_DEPTH];
   logic [31:0] q_pc   [IQ_DEPTH];
   logic [31:0] q_imm  [IQ_DEPTH];

   // Byte returning this cycle is merged in so PUSH can use the fourth byte without extra delay.
   always_comb begin
      word_cur = word_q;
      if (pend_q) word_cur[{pend_idx_q, 3'b000} +: 8] = mem_din;
   end

   assign push_imm  = decode_imm(word_cur);
   assign not_empty = (count_q != '0);
   assign issue     = (state_q == StIssue) && rdy_in && mem_grant;
   assign push      = (state_q == StPush) && rdy_in && !flush_in;
   assign pop       = have_input && !flush_in;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      pc_d       = pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      word_d     = word_cur;
      pend_d     = issue;
      pend_idx_d = k_q;
      if (rdy_in && flush_in) begin
         state_d = StIdle;
         k_d     = '0;
         pc_d    = flush_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         pend_d  = 1'b0;
      end else if (rdy_in) begin
         unique case (state_q)
            StIdle: if (count_q < CntFull) state_d = StIssue;
            StIssue: begin
               if (issue) begin
                  k_d = k_q + 2'd1;
                  if (k_q == 2'd3) state_d = StPush;
               end
            end
            StPush: begin
               state_d = StIdle;
               tail_d  = tail_q + PtrW'(1);
               pc_d    = pc_q + 32'd4;
`ifdef FETCH_PREDICT_EN
               if (word_cur[6:0] == OpJal) pc_d = pc_q + push_imm;
`endif
            end
            default: state_d = StIdle;
         endcase
         if (pop) head_d = head_q + PtrW'(1);
         if (push && !pop) count_d = count_q + CntW'(1);
         else if (pop && !push) count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= StIdle;
         k_q        <= '0;
         pc_q       <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         word_q     <= '0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         pc_q       <= pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         word_q     <= word_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && push) begin
         q_word[tail_q] <= word_cur;
         q_pc[tail_q]   <= pc_q;
         q_imm[tail_q]  <= push_imm;
      end
   end

   assign mem_req    = (state_q == StIssue) && rdy_in;
   assign mem_a      = (state_q == StIssue) ? pc_q + {30'b0, k_q} : '0;
   assign have_input = rdy_in && not_empty && !rob_full;

   // Entries are not reset, so the head is masked while the queue is empty.
   assign head_word      = not_empty ? q_word[head_q] : '0;
   assign instr_input    = head_word;
   assign instr_input_pc = not_empty ? q_pc[head_q] : '0;
   assign imm_if         = not_empty ? q_imm[head_q] : '0;
   assign opcode_if      = {head_word[31:25], head_word[14:12], head_word[6:0]};
   assign rd_if          = head_word[11:7];
   assign rs1_if         = head_word[19:15];
   assign rs2_if         = head_word[24:20];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: byte-addressed memory model plus an in-order
// reference stream of expected instructions (word, pc, decoded fields) derived from memory.
module tb_inst_fetch_queue;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, mem_grant, rob_full, flush_in;
   logic [7:0]  mem_din;
   logic [31:0] flush_pc;
   logic        mem_req, have_input;
   logic [31:0] mem_a, instr_input, instr_input_pc, imm_if;
   logic [16:0] opcode_if;
   logic [4:0]  rd_if, rs1_if, rs2_if;

   logic [7:0]   mem_arr [0:1023];
   logic [31:0]  exp_pc;
   logic [127:0] dut_view;
   int           n_checks = 0;
   int           n_fail = 0;

   inst_fetch_queue #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_grant(mem_grant),
      .mem_din(mem_din), .mem_req(mem_req), .mem_a(mem_a), .rob_full(rob_full),
      .flush_in(flush_in), .flush_pc(flush_pc), .have_input(have_input),
      .instr_input(instr_input), .instr_input_pc(instr_input_pc), .opcode_if(opcode_if),
      .rd_if(rd_if), .rs1_if(rs1_if), .rs2_if(rs2_if), .imm_if(imm_if)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) mem_din <= mem_arr[mem_a[9:0]];

   assign dut_view = {instr_input, instr_input_pc, opcode_if, rd_if, rs1_if, rs2_if, imm_if};

   function automatic logic [31:0] fetch_word(input logic [31:0] a);
      logic [9:0] b;
      b = a[9:0];
      return {mem_arr[b + 10'd3], mem_arr[b + 10'd2], mem_arr[b + 10'd1], mem_arr[b]};
   endfunction

   // Immediate as signed integer arithmetic on the encoded bit groups.
   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      int v;
      int s;
      v = 0;
      s = w[31] ? 1 : 0;
      case (w[6:0])
         7'h03, 7'h67: v = int'(w[30:20]) - 2048 * s;
         7'h13: begin
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5) v = int'(w[24:20]);
            else v = int'(w[30:20]) - 2048 * s;
         end
         7'h23: v = int'(w[11:7]) + 32 * int'(w[30:25]) - 2048 * s;
         7'h63: v = 2 * int'(w[11:8]) + 32 * int'(w[30:25]) + 2048 * int'(w[7]) - 4096 * s;
         7'h37, 7'h17: return w & 32'hFFFF_F000;
         7'h6F: v = 2 * int'(w[30:21]) + 2048 * int'(w[20]) + 4096 * int'(w[19:12])
                    - 1048576 * s;
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [127:0] ref_entry(input logic [31:0] pc);
      logic [31:0] w;
      w = fetch_word(pc);
      return {w, pc, w[31:25], w[14:12], w[6:0], w[11:7], w[19:15], w[24:20], ref_imm(w)};
   endfunction

   function automatic logic [31:0] ref_next_pc(input logic [31:0] pc);
      logic [31:0] w;
      w = fetch_word(pc);
`ifdef FETCH_PREDICT_EN
      if (w[6:0] == 7'h6F) return pc + ref_imm(w);
`endif
      return pc + 32'd4;
   endfunction

   task automatic do_reset(input logic full, input logic grant);
      rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; flush_pc = '0;
      rob_full = full; mem_grant = grant;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      exp_pc = 32'h0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; flush_pc = '0;
      rob_full = 1'b0; mem_grant = 1'b1;
      repeat (3) @(negedge clk_in);
      #1;
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      n_checks++;
      if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
      n_checks++;
      if (have_input !== 1'b0) begin
         n_fail++; $display("FAIL reset_have_input got %b want 0", have_input);
      end
      n_checks++;
      if (dut_view !== 128'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", dut_view); end
   endtask

   task automatic test_first_instr();
      logic [127:0] want, got;
      int found;
      mem_arr[0] = 8'h13; mem_arr[1] = 8'h05; mem_arr[2] = 8'hA0; mem_arr[3] = 8'h00;
      want = {32'h00A00513, 32'h0, 7'b0, 3'b000, 7'b0010011, 5'd10, 5'd0, 5'd10, 32'd10};
      do_reset(1'b0, 1'b1);
      found = -1;
      got = '0;
      for (int c = 0; c <= 12 && found < 0; c++) begin
         if (c > 0) @(negedge clk_in);
         #1;
         if (c == 4) begin
            n_checks++;
            if (!(mem_req === 1'b1 && mem_a === 32'h3)) begin
               n_fail++; $display("FAIL first_byte3_addr got req=%b a=%h want req=1 a=3", mem_req, mem_a);
            end
         end
         if (have_input === 1'b1) begin found = c; got = dut_view; end
      end
      n_checks++;
      if (found != 6) begin n_fail++; $display("FAIL first_latency got %0d want 6", found); end
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL first_fields got %h want %h", got, want); end
   endtask

   task automatic test_fill_full();
      int issues, bad, pops;
      do_reset(1'b1, 1'b1);
      issues = 0; bad = 0;
      for (int c = 0; c < 60; c++) begin
         if (c > 0) @(negedge clk_in);
         #1;
         if (mem_req && mem_grant) issues++;
         if (have_input) bad++;
      end
      n_checks++;
      if (issues != 16) begin n_fail++; $display("FAIL full_issue_count got %0d want 16", issues); end
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_mem_req got %b want 0", mem_req); end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL full_have_input got %0d pops want 0", bad); end
      pops = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk_in);
         rob_full = 1'b0;
         #1;
         if (have_input) begin
            n_checks++;
            if (dut_view !== ref_entry(exp_pc) || instr_input_pc !== 32'(4 * pops)) begin
               n_fail++;
               $display("FAIL full_drain_%0d got %h want %h", pops, dut_view, ref_entry(exp_pc));
            end
            exp_pc = ref_next_pc(exp_pc);
            pops++;
         end
      end
      n_checks++;
      if (pops != 4) begin n_fail++; $display("FAIL full_drain_count got %0d want 4", pops); end
   endtask

   task automatic test_grant_toggle();
      int first, pops;
      do_reset(1'b0, 1'b0);
      first = -1; pops = 0;
      for (int c = 0; c < 60 && pops < 4; c++) begin
         if (c > 0) @(negedge clk_in);
         mem_grant = c[0];
         #1;
         if (have_input) begin
            if (first < 0) first = c;
            n_checks++;
            if (dut_view !== ref_entry(exp_pc)) begin
               n_fail++;
               $display("FAIL toggle_word_%0d got %h want %h", pops, dut_view, ref_entry(exp_pc));
            end
            exp_pc = ref_next_pc(exp_pc);
            pops++;
         end
      end
      n_checks++;
      if (first != 9) begin n_fail++; $display("FAIL toggle_latency got %0d want 9", first); end
      n_checks++;
      if (pops != 4) begin n_fail++; $display("FAIL toggle_pops got %0d want 4", pops); end
   endtask

   task automatic test_flush();
      logic hit;
      logic [31:0] addr;
      do_reset(1'b1, 1'b1);
      hit = 1'b0;
      for (int c = 0; c < 30 && !hit; c++) begin
         if (c > 0) @(negedge clk_in);
         #1;
         if (mem_req && mem_a == 32'h6) begin
            hit = 1'b1; flush_in = 1'b1; flush_pc = 32'h100;
         end
      end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL flush_setup got no byte-2 issue want one"); end
      @(negedge clk_in);
      flush_in = 1'b0; rob_full = 1'b0;
      #1;
      n_checks++;
      if (have_input !== 1'b0) begin
         n_fail++; $display("FAIL flush_empty got have_input=%b want 0", have_input);
      end
      hit = 1'b0; addr = 'x;
      for (int c = 0; c < 6 && !hit; c++) begin
         @(negedge clk_in);
         #1;
         if (mem_req) begin hit = 1'b1; addr = mem_a; end
      end
      n_checks++;
      if (addr !== 32'h100) begin n_fail++; $display("FAIL flush_next_addr got %h want 100", addr); end
      exp_pc = 32'h100;
      hit = 1'b0;
      for (int c = 0; c < 12 && !hit; c++) begin
         @(negedge clk_in);
         #1;
         if (have_input) begin
            hit = 1'b1;
            n_checks++;
            if (dut_view !== ref_entry(exp_pc)) begin
               n_fail++; $display("FAIL flush_first_pop got %h want %h", dut_view, ref_entry(exp_pc));
            end
         end
      end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL flush_pop_timeout got none want one"); end
   endtask

   task automatic test_imm_decode();
      logic [31:0] words [3];
      logic [31:0] imms [3];
      int pops;
      words[0] = 32'hFE010EE3; imms[0] = 32'hFFFFFFFC;
      words[1] = 32'h800000B7; imms[1] = 32'h80000000;
      words[2] = 32'h40235093; imms[2] = 32'h00000002;
      for (int i = 0; i < 3; i++)
         for (int b = 0; b < 4; b++) mem_arr[10'h200 + 10'(4 * i + b)] = words[i][8 * b +: 8];
      do_reset(1'b0, 1'b1);
      flush_in = 1'b1; flush_pc = 32'h200;
      @(negedge clk_in);
      flush_in = 1'b0;
      pops = 0;
      for (int c = 0; c < 40 && pops < 3; c++) begin
         @(negedge clk_in);
         #1;
         if (have_input) begin
            n_checks++;
            if (imm_if !== imms[pops] || instr_input !== words[pops]
                || instr_input_pc !== 32'h200 + 32'(4 * pops)) begin
               n_fail++;
               $display("FAIL imm_%0d got instr=%h imm=%h pc=%h want instr=%h imm=%h",
                        pops, instr_input, imm_if, instr_input_pc, words[pops], imms[pops]);
            end
            pops++;
         end
      end
      n_checks++;
      if (pops != 3) begin n_fail++; $display("FAIL imm_pops got %0d want 3", pops); end
   endtask

   task automatic test_jal();
      logic [31:0] want, got;
      int n;
      mem_arr[10'h300] = 8'h6F; mem_arr[10'h301] = 8'h00;
      mem_arr[10'h302] = 8'h00; mem_arr[10'h303] = 8'h01;
`ifdef FETCH_PREDICT_EN
      want = 32'h310;
`else
      want = 32'h304;
`endif
      do_reset(1'b0, 1'b1);
      flush_in = 1'b1; flush_pc = 32'h300;
      @(negedge clk_in);
      flush_in = 1'b0;
      n = 0; got = 'x;
      for (int c = 0; c < 30 && n < 5; c++) begin
         @(negedge clk_in);
         #1;
         if (mem_req && mem_grant) begin
            if (n == 4) got = mem_a;
            n++;
         end
         if (have_input && instr_input_pc == 32'h300) begin
            n_checks++;
            if (imm_if !== 32'h10) begin n_fail++; $display("FAIL jal_imm got %h want 10", imm_if); end
         end
      end
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL jal_next_addr got %h want %h", got, want); end
   endtask

   task automatic test_random();
      int pops;
      do_reset(1'b0, 1'b1);
      pops = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c > 0) @(negedge clk_in);
         rdy_in    = ($urandom % 8) != 0;
         mem_grant = ($urandom % 3) != 0;
         rob_full  = ($urandom % 4) == 0;
         flush_in  = ($urandom % 64) == 0;
         flush_pc  = 32'($urandom_range(0, 255)) * 32'd4;
         #1;
         n_checks++;
         if (have_input && rob_full) begin
            n_fail++; $display("FAIL rand_pop_while_full got have_input=1 want 0 at cycle %0d", c);
         end
         if (rdy_in && flush_in) begin
            exp_pc = flush_pc;
         end else if (have_input && rdy_in) begin
            n_checks++;
            if (dut_view !== ref_entry(exp_pc)) begin
               n_fail++;
               $display("FAIL rand_pop_%0d got %h want %h", pops, dut_view, ref_entry(exp_pc));
            end
            exp_pc = ref_next_pc(exp_pc);
            pops++;
         end
      end
      @(negedge clk_in);
      flush_in = 1'b0; rdy_in = 1'b1;
      n_checks++;
      if (pops < 100) begin n_fail++; $display("FAIL rand_throughput got %0d pops want >=100", pops); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) mem_arr[4 * i] = 8'h13;
      test_reset();
      test_first_instr();
      test_fill_full();
      test_grant_toggle();
      test_flush();
      test_imm_decode();
      test_jal();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
